// File: rtl/matrix_operand_loader.sv
// Element-stream front end for the 2x2 matrix multiplier: packs A/B operands, waits a settle window, captures sum_out.
// Optional MATLOAD_REUSE_B_EN adds keep_b to reuse the previously loaded B operand.
module matrix_operand_loader #(
    parameter int ELEM_W = 4,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ELEM_W-1:0]     in_data,
    output logic [4*ELEM_W-1:0]   arr,
    output logic [4*ELEM_W-1:0]   brr,
    input  logic [8*ELEM_W-1:0]   mult_sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*ELEM_W-1:0]   out_data,
`ifdef MATLOAD_REUSE_B_EN
    input  logic                  keep_b,
`endif
    output logic                  busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [2:0]              state_reg, state_next;
    logic [1:0]              idx_reg, idx_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic                    in_ready_reg, in_ready_next;
    logic                    out_valid_reg, out_valid_next;
    logic [8*ELEM_W-1:0]     out_data_reg, out_data_next;
    logic [4*ELEM_W-1:0]     arr_reg, arr_next;
    logic [4*ELEM_W-1:0]     brr_reg, brr_next;

    // A keeps all four slots because arr is built only when B completes.
    logic [ELEM_W-1:0]       a_shadow_reg [4];
    logic [ELEM_W-1:0]       b_shadow_reg [3];
    logic [4*ELEM_W-1:0]     a_pack_full;
    logic [4*ELEM_W-1:0]     b_pack_in;

    logic accept;
    assign accept = in_valid && in_ready_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_a_pack
            assign a_pack_full[(3-gi)*ELEM_W +: ELEM_W] = a_shadow_reg[gi];
        end
        for (gi = 0; gi < 3; gi++) begin : g_b_pack
            assign b_pack_in[(3-gi)*ELEM_W +: ELEM_W] = b_shadow_reg[gi];
        end
    endgenerate
    assign b_pack_in[ELEM_W-1:0] = in_data;

`ifdef MATLOAD_REUSE_B_EN
    logic                    keep_b_reg, keep_b_next;
    logic [4*ELEM_W-1:0]     a_pack_in;
    assign a_pack_in = {a_pack_full[4*ELEM_W-1:ELEM_W], in_data};
`endif

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        cnt_next       = cnt_reg;
        in_ready_next  = in_ready_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        arr_next       = arr_reg;
        brr_next       = brr_reg;
`ifdef MATLOAD_REUSE_B_EN
        keep_b_next    = keep_b_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                state_next    = ST_LOAD_A;
                in_ready_next = 1'b1;
            end
            ST_LOAD_A: begin
                if (accept) begin
                    idx_next = idx_reg + 2'd1;
`ifdef MATLOAD_REUSE_B_EN
                    if (idx_reg == 2'd0)
                        keep_b_next = keep_b;
                    if (idx_reg == 2'd3) begin
                        if (keep_b_reg) begin
                            arr_next      = a_pack_in;
                            in_ready_next = 1'b0;
                            cnt_next      = 4'd0;
                            state_next    = ST_ISSUE;
                        end else begin
                            state_next = ST_LOAD_B;
                        end
                    end
`else
                    if (idx_reg == 2'd3)
                        state_next = ST_LOAD_B;
`endif
                end
            end
            ST_LOAD_B: begin
                if (accept) begin
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        // Both operands switch on the same edge so the multiplier never sees a mix.
                        arr_next      = a_pack_full;
                        brr_next      = b_pack_in;
                        in_ready_next = 1'b0;
                        cnt_next      = 4'd0;
                        state_next    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == SETTLE_LAST) begin
                    out_data_next  = mult_sum;
                    out_valid_next = 1'b1;
                    state_next     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_valid_reg && out_ready) begin
                    out_valid_next = 1'b0;
                    in_ready_next  = 1'b1;
                    state_next     = ST_LOAD_A;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= 2'd0;
            cnt_reg       <= 4'd0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            arr_reg       <= '0;
            brr_reg       <= '0;
`ifdef MATLOAD_REUSE_B_EN
            keep_b_reg    <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            arr_reg       <= arr_next;
            brr_reg       <= brr_next;
`ifdef MATLOAD_REUSE_B_EN
            keep_b_reg    <= keep_b_next;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) a_shadow_reg[i] <= '0;
            for (int i = 0; i < 3; i++) b_shadow_reg[i] <= '0;
        end else if (accept) begin
            if (state_reg == ST_LOAD_A)
                a_shadow_reg[idx_reg] <= in_data;
            if (state_reg == ST_LOAD_B) begin
                for (int i = 0; i < 3; i++)
                    if (idx_reg == 2'(i))
                        b_shadow_reg[i] <= in_data;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign arr       = arr_reg;
    assign brr       = brr_reg;
    assign busy      = !((state_reg == ST_IDLE) ||
                         ((state_reg == ST_LOAD_A) && (idx_reg == 2'd0)));

endmodule
